// File: rtl/mem_wb_queue.sv
// MEM/WB writeback queue: resolves ALU/LOAD/MUL/VPU results, aligns loads, buffers them in a DEPTH-entry FIFO.
// Optional MEM_WB_BYPASS_EN: 0-cycle bypass of a resolved result straight onto wb_* when the queue is empty.
module mem_wb_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int RD_W  = 5
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    output logic                         stall_o,
    input  logic [1:0]                   in_fu_i,
    input  logic [RD_W-1:0]              in_rd_i,
    input  logic [XLEN-1:0]              in_result_i,
    input  logic [1:0]                   in_ld_size_i,
    input  logic                         in_ld_unsigned_i,
    input  logic [XLEN-1:0]              mul_result_i,
    input  logic                         dcache_wait_i,
    input  logic [XLEN-1:0]              dcache_data_i,
    input  logic                         vpu_valid_i,
    input  logic [XLEN-1:0]              vpu_result_i,
    output logic                         wb_valid_o,
    input  logic                         wb_ready_i,
    output logic [RD_W-1:0]              wb_rd_o,
    output logic [XLEN-1:0]              wb_data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int OFF_W = $clog2(XLEN/8);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    localparam logic [1:0] FU_ALU  = 2'd0;
    localparam logic [1:0] FU_LOAD = 2'd1;
    localparam logic [1:0] FU_MUL  = 2'd2;
    localparam logic [1:0] FU_VPU  = 2'd3;

    logic [RD_W-1:0]  rd_q   [DEPTH];
    logic [XLEN-1:0]  data_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic             resolved;
    logic [XLEN-1:0]  res_data;
    logic [OFF_W+2:0] sh_amt;
    logic [XLEN-1:0]  ld_shift;
    logic [XLEN-1:0]  ld_ext;
    logic             fifo_valid;
    logic             push;
    logic             pop;
    logic             bypass_take;

    assign sh_amt   = {in_result_i[OFF_W-1:0], 3'b000};
    assign ld_shift = dcache_data_i >> sh_amt;

    always_comb begin
        ld_ext = '0;
        case (in_ld_size_i)
            2'd0: ld_ext = in_ld_unsigned_i ? XLEN'(ld_shift[7:0])  : XLEN'($signed(ld_shift[7:0]));
            2'd1: ld_ext = in_ld_unsigned_i ? XLEN'(ld_shift[15:0]) : XLEN'($signed(ld_shift[15:0]));
            default: begin
                // a D access on a 32-bit datapath degrades to W
                if (XLEN == 64 && in_ld_size_i == 2'd3) ld_ext = ld_shift;
                else ld_ext = in_ld_unsigned_i ? XLEN'(ld_shift[31:0]) : XLEN'($signed(ld_shift[31:0]));
            end
        endcase
    end

    always_comb begin
        resolved = 1'b1;
        res_data = in_result_i;
        case (in_fu_i)
            FU_ALU:  res_data = in_result_i;
            FU_LOAD: begin
                resolved = ~dcache_wait_i;
                res_data = ld_ext;
            end
            FU_MUL:  res_data = mul_result_i;
            FU_VPU:  begin
                resolved = vpu_valid_i;
                res_data = vpu_result_i;
            end
            default: res_data = in_result_i;
        endcase
    end

    assign fifo_valid = (count_q != '0);
    assign pop        = fifo_valid & wb_ready_i & ~flush_i;

`ifdef MEM_WB_BYPASS_EN
    logic bypass;
    assign bypass      = rst_ni & in_valid_i & resolved & ~flush_i & ~fifo_valid;
    assign bypass_take = bypass & wb_ready_i;
    assign wb_valid_o  = fifo_valid | bypass;
    assign wb_rd_o     = fifo_valid ? rd_q[rd_ptr_q]   : (bypass ? in_rd_i  : '0);
    assign wb_data_o   = fifo_valid ? data_q[rd_ptr_q] : (bypass ? res_data : '0);
`else
    assign bypass_take = 1'b0;
    assign wb_valid_o  = fifo_valid;
    assign wb_rd_o     = rd_q[rd_ptr_q];
    assign wb_data_o   = data_q[rd_ptr_q];
`endif

    assign push = in_valid_i & resolved & ~flush_i & ~bypass_take &
                  ((count_q < CNT_W'(DEPTH)) | (wb_ready_i & fifo_valid));

    assign in_ready_o = push | bypass_take;
    assign stall_o    = in_valid_i & ~in_ready_o;
    assign count_o    = count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                rd_q[wr_ptr_q]   <= in_rd_i;
                data_q[wr_ptr_q] <= res_data;
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb_queue.sv
// Directed bench for mem_wb_queue (default 32-bit/DEPTH=2 instance plus a 64-bit instance for D loads).
module tb_mem_wb_queue;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i, in_valid_i, in_ld_unsigned_i, dcache_wait_i, vpu_valid_i, wb_ready_i;
    logic [1:0]  in_fu_i, in_ld_size_i;
    logic [4:0]  in_rd_i;
    logic [31:0] in_result_i, mul_result_i, dcache_data_i, vpu_result_i;
    logic        in_ready_o, stall_o, wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic [1:0]  count_o;

    logic        v64_in_valid;
    logic [1:0]  v64_size;
    logic        v64_uns;
    logic [63:0] v64_addr, v64_dc;
    logic        v64_ready, v64_stall, v64_wb_valid;
    logic [4:0]  v64_wb_rd;
    logic [63:0] v64_wb_data;
    logic [1:0]  v64_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    mem_wb_queue #(.XLEN(32), .DEPTH(2), .RD_W(5)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .stall_o(stall_o),
        .in_fu_i(in_fu_i), .in_rd_i(in_rd_i), .in_result_i(in_result_i),
        .in_ld_size_i(in_ld_size_i), .in_ld_unsigned_i(in_ld_unsigned_i),
        .mul_result_i(mul_result_i), .dcache_wait_i(dcache_wait_i), .dcache_data_i(dcache_data_i),
        .vpu_valid_i(vpu_valid_i), .vpu_result_i(vpu_result_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_rd_o(wb_rd_o),
        .wb_data_o(wb_data_o), .count_o(count_o)
    );

    mem_wb_queue #(.XLEN(64), .DEPTH(2), .RD_W(5)) dut64 (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(1'b0),
        .in_valid_i(v64_in_valid), .in_ready_o(v64_ready), .stall_o(v64_stall),
        .in_fu_i(2'd1), .in_rd_i(5'd9), .in_result_i(v64_addr),
        .in_ld_size_i(v64_size), .in_ld_unsigned_i(v64_uns),
        .mul_result_i(64'd0), .dcache_wait_i(1'b0), .dcache_data_i(v64_dc),
        .vpu_valid_i(1'b0), .vpu_result_i(64'd0),
        .wb_valid_o(v64_wb_valid), .wb_ready_i(1'b1), .wb_rd_o(v64_wb_rd),
        .wb_data_o(v64_wb_data), .count_o(v64_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // One-cycle op with wb_ready_i=1: check the value at the head next cycle, then let it drain.
    task automatic one_op(input string tag, input logic [1:0] fu, input logic [31:0] res,
                          input logic [1:0] size, input logic uns, input logic [31:0] exp);
        in_valid_i = 1'b1; in_fu_i = fu; in_rd_i = 5'd7; in_result_i = res;
        in_ld_size_i = size; in_ld_unsigned_i = uns;
        #1 chk({tag, "_rdy"}, 64'(in_ready_o), 64'd1);
        step();
        in_valid_i = 1'b0;
        chk(tag, 64'(wb_data_o), 64'(exp));
        step();
    endtask

    initial begin
        rst_ni = 1'b0; flush_i = 0; in_valid_i = 0; in_ld_unsigned_i = 0; dcache_wait_i = 0;
        vpu_valid_i = 0; wb_ready_i = 0; in_fu_i = 0; in_ld_size_i = 0; in_rd_i = 0;
        in_result_i = 0; mul_result_i = 0; dcache_data_i = 0; vpu_result_i = 0;
        v64_in_valid = 0; v64_size = 0; v64_uns = 0; v64_addr = 0; v64_dc = 0;
        #3;
        chk("rst_valid", 64'(wb_valid_o), 64'd0);
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_data", 64'(wb_data_o), 64'd0);
        chk("rst_rd", 64'(wb_rd_o), 64'd0);
        step(); step();
        rst_ni = 1'b1;
        step();

        // ALU latency
        wb_ready_i = 1'b1;
        in_valid_i = 1'b1; in_fu_i = 2'd0; in_rd_i = 5'd3; in_result_i = 32'h1234;
        #1 chk("alu_rdy", 64'(in_ready_o), 64'd1);
        chk("alu_novalid_same_cycle", 64'(wb_valid_o), 64'd0);
        step();
        in_valid_i = 1'b0;
        chk("alu_valid", 64'(wb_valid_o), 64'd1);
        chk("alu_rd", 64'(wb_rd_o), 64'd3);
        chk("alu_data", 64'(wb_data_o), 64'h1234);
        chk("alu_cnt1", 64'(count_o), 64'd1);
        step();
        chk("alu_cnt0", 64'(count_o), 64'd0);
        chk("alu_drained", 64'(wb_valid_o), 64'd0);

        // Load alignment / extension
        dcache_data_i = 32'h80FF7F01;
        one_op("ld_h_s",    2'd1, 32'h1002, 2'd1, 1'b0, 32'hFFFF80FF);
        one_op("ld_h_u",    2'd1, 32'h1002, 2'd1, 1'b1, 32'h000080FF);
        one_op("ld_b1_s",   2'd1, 32'h1001, 2'd0, 1'b0, 32'h0000007F);
        one_op("ld_b3_s",   2'd1, 32'h1003, 2'd0, 1'b0, 32'hFFFFFF80);
        one_op("ld_w",      2'd1, 32'h1000, 2'd2, 1'b0, 32'h80FF7F01);
        one_op("ld_d_as_w", 2'd1, 32'h1000, 2'd3, 1'b0, 32'h80FF7F01);
        mul_result_i = 32'hDEAD_BEEF;
        one_op("mul", 2'd2, 32'h5, 2'd0, 1'b0, 32'hDEADBEEF);

        // D$ wait
        in_valid_i = 1'b1; in_fu_i = 2'd1; in_result_i = 32'h2; in_ld_size_i = 2'd1;
        in_ld_unsigned_i = 1'b1; dcache_wait_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("dwait_stall", 64'(stall_o), 64'd1);
            chk("dwait_rdy", 64'(in_ready_o), 64'd0);
            step();
        end
        dcache_wait_i = 1'b0;
        #1 chk("dwait_rdy4", 64'(in_ready_o), 64'd1);
        step();
        in_valid_i = 1'b0;
        chk("dwait_data", 64'(wb_data_o), 64'h80FF);
        chk("dwait_cnt", 64'(count_o), 64'd1);
        step();

        // Full FIFO
        wb_ready_i = 1'b0;
        in_valid_i = 1'b1; in_fu_i = 2'd0; in_rd_i = 5'd1; in_result_i = 32'd1;
        step();
        in_rd_i = 5'd2; in_result_i = 32'd2;
        step();
        in_rd_i = 5'd3; in_result_i = 32'd3;
        #1;
        chk("full_rdy", 64'(in_ready_o), 64'd0);
        chk("full_stall", 64'(stall_o), 64'd1);
        chk("full_cnt", 64'(count_o), 64'd2);
        step();
        chk("full_cnt_hold", 64'(count_o), 64'd2);
        chk("full_head1", 64'(wb_data_o), 64'd1);
        wb_ready_i = 1'b1;
        #1 chk("full_pushpop_rdy", 64'(in_ready_o), 64'd1);
        step();
        in_valid_i = 1'b0;
        chk("full_pp_cnt", 64'(count_o), 64'd2);
        chk("full_head2", 64'(wb_data_o), 64'd2);
        chk("full_rd2", 64'(wb_rd_o), 64'd2);
        step();
        chk("full_head3", 64'(wb_data_o), 64'd3);
        chk("full_cnt1", 64'(count_o), 64'd1);
        step();
        chk("full_cnt0", 64'(count_o), 64'd0);

        // Flush
        wb_ready_i = 1'b0;
        in_valid_i = 1'b1; in_result_i = 32'hA;
        step();
        in_result_i = 32'hB;
        step();
        chk("fl_cnt2", 64'(count_o), 64'd2);
        flush_i = 1'b1; wb_ready_i = 1'b1; in_result_i = 32'hC;
        #1 chk("fl_rdy", 64'(in_ready_o), 64'd0);
        step();
        flush_i = 1'b0; in_valid_i = 1'b0;
        chk("fl_cnt0", 64'(count_o), 64'd0);
        chk("fl_valid", 64'(wb_valid_o), 64'd0);
        step();
        chk("fl_stays_empty", 64'(count_o), 64'd0);

        // VPU
        wb_ready_i = 1'b1;
        in_valid_i = 1'b1; in_fu_i = 2'd3; in_rd_i = 5'd4; vpu_result_i = 32'h55; vpu_valid_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1 chk("vpu_wait_rdy", 64'(in_ready_o), 64'd0);
            step();
        end
        vpu_valid_i = 1'b1;
        #1 chk("vpu_rdy", 64'(in_ready_o), 64'd1);
        step();
        in_valid_i = 1'b0; vpu_valid_i = 1'b0;
        chk("vpu_data", 64'(wb_data_o), 64'h55);
        chk("vpu_rd", 64'(wb_rd_o), 64'd4);
        step();

        // XLEN=64 loads
        v64_dc = 64'h8123_4567_89AB_CDEF;
        v64_in_valid = 1'b1; v64_addr = 64'h100; v64_size = 2'd3; v64_uns = 1'b0;
        step();
        chk("x64_d", v64_wb_data, 64'h8123456789ABCDEF);
        v64_addr = 64'h104; v64_size = 2'd2;
        step();
        chk("x64_w_hi_s", v64_wb_data, 64'hFFFF_FFFF_8123_4567);
        v64_addr = 64'h106; v64_size = 2'd1; v64_uns = 1'b1;
        step();
        v64_in_valid = 1'b0;
        chk("x64_h_u", v64_wb_data, 64'h0000_0000_0000_8123);
        step();

        // Reset mid-operation
        wb_ready_i = 1'b0;
        in_valid_i = 1'b1; in_fu_i = 2'd0; in_rd_i = 5'd6; in_result_i = 32'h77;
        step();
        in_valid_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        chk("mrst_valid", 64'(wb_valid_o), 64'd0);
        chk("mrst_data", 64'(wb_data_o), 64'd0);
        chk("mrst_count", 64'(count_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
